// File: rtl/cacheline_burst_responder_if.sv
// rtl/cacheline_burst_responder_if.sv - line-side and burst-side handshake bundles
// Line side: requester is master. Burst side: responder is master.

interface line_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic [ADDR_WIDTH-1:0] line_address;
  logic [LINE_WIDTH-1:0] line_rdata;
  logic [LINE_WIDTH-1:0] line_wdata;
  logic                  line_read;
  logic                  line_write;
  logic                  line_resp;

  modport master (
    output line_address, line_wdata, line_read, line_write,
    input  line_rdata, line_resp
  );

  modport slave (
    input  line_address, line_wdata, line_read, line_write,
    output line_rdata, line_resp
  );
endinterface

interface burst_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] burst_address;
  logic [BEAT_WIDTH-1:0] burst_rdata;
  logic [BEAT_WIDTH-1:0] burst_wdata;
  logic                  burst_read;
  logic                  burst_write;
  logic                  burst_resp;

  modport master (
    output burst_address, burst_wdata, burst_read, burst_write,
    input  burst_rdata, burst_resp
  );

  modport slave (
    input  burst_address, burst_wdata, burst_read, burst_write,
    output burst_rdata, burst_resp
  );
endinterface

// File: rtl/cacheline_burst_responder.sv
// rtl/cacheline_burst_responder.sv - converts one 256-bit line request into a 4-beat burst
// Single outstanding request; address and write data are latched on acceptance.

module cacheline_burst_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst,
  line_mem_if.slave      line,
  burst_mem_if.master    burst
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS   = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFS) - ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] aligned;

  assign cnt_next = cnt + 1'b1;
  assign aligned  = line.line_address & ALIGN_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      wdata_q             <= '0;
      line.line_rdata     <= '0;
      line.line_resp      <= 1'b0;
      burst.burst_read    <= 1'b0;
      burst.burst_write   <= 1'b0;
      burst.burst_address <= '0;
      burst.burst_wdata   <= '0;
    end else begin
      line.line_resp <= 1'b0;
      case (state)
        IDLE: begin
          // Write wins when both requests are presented together.
          if (line.line_write) begin
            burst.burst_address <= aligned;
            wdata_q             <= line.line_wdata;
            burst.burst_wdata   <= line.line_wdata[BEAT_WIDTH-1:0];
            burst.burst_write   <= 1'b1;
            cnt                 <= '0;
            state               <= WRITE;
          end else if (line.line_read) begin
            burst.burst_address <= aligned;
            burst.burst_read    <= 1'b1;
            cnt                 <= '0;
            state               <= READ;
          end
        end
        READ: begin
          if (burst.burst_resp) begin
            line.line_rdata[BEAT_WIDTH*cnt +: BEAT_WIDTH] <= burst.burst_rdata;
            cnt <= cnt_next;
            if (cnt == LAST) begin
              burst.burst_read <= 1'b0;
              line.line_resp   <= 1'b1;
              state            <= DONE;
            end
          end
        end
        WRITE: begin
          if (burst.burst_resp) begin
            cnt <= cnt_next;
            if (cnt == LAST) begin
              burst.burst_write <= 1'b0;
              line.line_resp    <= 1'b1;
              state             <= DONE;
            end else begin
              burst.burst_wdata <= wdata_q[BEAT_WIDTH*cnt_next +: BEAT_WIDTH];
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_responder.sv
// tb/tb_cacheline_burst_responder.sv - directed self-checking bench for cacheline_burst_responder
// Inputs driven and outputs sampled 1 time unit after each rising edge.

module tb_cacheline_burst_responder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  line_mem_if  #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) line_bus ();
  burst_mem_if #(.ADDR_WIDTH(32), .BEAT_WIDTH(64))  burst_bus ();

  cacheline_burst_responder #(
    .ADDR_WIDTH(32),
    .LINE_WIDTH(256),
    .BEAT_WIDTH(64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .line  (line_bus),
    .burst (burst_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [63:0]  rb [4];
  logic [63:0]  rb2 [4];
  logic [63:0]  wexp [4];
  logic [255:0] read_line;
  logic [255:0] read_line2;
  logic [255:0] wline;
  int           pattern [7];
  int           k;

  initial begin
    checks   = 0;
    failures = 0;
    rb[0] = 64'h1111_1111_1111_1111;
    rb[1] = 64'h2222_2222_2222_2222;
    rb[2] = 64'h3333_3333_3333_3333;
    rb[3] = 64'h4444_4444_4444_4444;
    read_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    rb2[0] = 64'hAAAA_0000_0000_0001;
    rb2[1] = 64'hAAAA_0000_0000_0002;
    rb2[2] = 64'hAAAA_0000_0000_0003;
    rb2[3] = 64'hAAAA_0000_0000_0004;
    read_line2 = {64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0003,
                  64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    wline = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
    wexp[0] = 64'h8899AABBCCDDEEFF;
    wexp[1] = 64'h0011223344556677;
    wexp[2] = 64'hFEDCBA9876543210;
    wexp[3] = 64'h0123456789ABCDEF;
    pattern = '{1, 0, 0, 1, 1, 0, 1};

    rst = 1'b1;
    line_bus.line_address = '0;
    line_bus.line_wdata   = '0;
    line_bus.line_read    = 1'b0;
    line_bus.line_write   = 1'b0;
    burst_bus.burst_rdata = '0;
    burst_bus.burst_resp  = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("reset_line_resp",  256'(line_bus.line_resp), 256'(0));
    check("reset_burst_read", 256'(burst_bus.burst_read), 256'(0));
    check("reset_burst_write", 256'(burst_bus.burst_write), 256'(0));
    check("reset_burst_addr", 256'(burst_bus.burst_address), 256'(0));
    check("reset_burst_wdata", 256'(burst_bus.burst_wdata), 256'(0));
    check("reset_line_rdata", line_bus.line_rdata, 256'(0));

    // Zero-wait read
    line_bus.line_address = 32'h0000_1234;
    line_bus.line_read    = 1'b1;
    burst_bus.burst_resp  = 1'b1;
    step();
    check("rd_burst_addr", 256'(burst_bus.burst_address), 256'(32'h0000_1220));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd_burst_read_c%0d", i + 1), 256'(burst_bus.burst_read), 256'(1));
      check($sformatf("rd_line_resp_c%0d", i + 1), 256'(line_bus.line_resp), 256'(0));
      burst_bus.burst_rdata = rb[i];
      step();
    end
    check("rd_line_resp_c5", 256'(line_bus.line_resp), 256'(1));
    check("rd_burst_read_c5", 256'(burst_bus.burst_read), 256'(0));
    check("rd_line_rdata", line_bus.line_rdata, read_line);
    line_bus.line_read   = 1'b0;
    burst_bus.burst_resp = 1'b0;
    step();
    check("rd_line_resp_c6", 256'(line_bus.line_resp), 256'(0));

    // Write with stalled beats
    line_bus.line_address = 32'h0000_2040;
    line_bus.line_wdata   = wline;
    line_bus.line_write   = 1'b1;
    step();
    line_bus.line_wdata   = '1;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("wr_burst_write_s%0d", i), 256'(burst_bus.burst_write), 256'(1));
      check($sformatf("wr_burst_wdata_s%0d", i), 256'(burst_bus.burst_wdata), 256'(wexp[k]));
      check($sformatf("wr_line_resp_s%0d", i), 256'(line_bus.line_resp), 256'(0));
      burst_bus.burst_resp = pattern[i][0];
      step();
      if (pattern[i] != 0) k++;
    end
    check("wr_line_resp", 256'(line_bus.line_resp), 256'(1));
    check("wr_burst_write_done", 256'(burst_bus.burst_write), 256'(0));
    check("wr_rdata_kept", line_bus.line_rdata, read_line);
    line_bus.line_write  = 1'b0;
    burst_bus.burst_resp = 1'b0;
    step();
    check("wr_line_resp_after", 256'(line_bus.line_resp), 256'(0));

    // Read and write together: write wins
    line_bus.line_address = 32'h0000_3000;
    line_bus.line_wdata   = wline;
    line_bus.line_read    = 1'b1;
    line_bus.line_write   = 1'b1;
    step();
    check("both_burst_write", 256'(burst_bus.burst_write), 256'(1));
    check("both_burst_read", 256'(burst_bus.burst_read), 256'(0));
    burst_bus.burst_resp  = 1'b1;
    burst_bus.burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 4; i++) step();
    check("both_line_resp", 256'(line_bus.line_resp), 256'(1));
    check("both_rdata_kept", line_bus.line_rdata, read_line);
    line_bus.line_read   = 1'b0;
    line_bus.line_write  = 1'b0;
    burst_bus.burst_resp = 1'b0;
    step();

    // Reset in the middle of a read burst
    line_bus.line_address = 32'h0000_4000;
    line_bus.line_read    = 1'b1;
    step();
    burst_bus.burst_resp  = 1'b1;
    burst_bus.burst_rdata = 64'h5555_5555_5555_5555;
    step();
    step();
    check("rst_mid_pre_read", 256'(burst_bus.burst_read), 256'(1));
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_burst_read", 256'(burst_bus.burst_read), 256'(0));
    check("rst_mid_line_resp", 256'(line_bus.line_resp), 256'(0));
    check("rst_mid_line_rdata", line_bus.line_rdata, 256'(0));
    check("rst_mid_burst_addr", 256'(burst_bus.burst_address), 256'(0));
    line_bus.line_read   = 1'b0;
    burst_bus.burst_resp = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("rst_after_burst_read", 256'(burst_bus.burst_read), 256'(0));
    check("rst_after_line_resp", 256'(line_bus.line_resp), 256'(0));

    // Fresh read after reset runs a full burst from beat 0
    line_bus.line_address = 32'h0000_501F;
    line_bus.line_read    = 1'b1;
    burst_bus.burst_resp  = 1'b1;
    step();
    check("rd2_burst_addr", 256'(burst_bus.burst_address), 256'(32'h0000_5000));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd2_line_resp_c%0d", i + 1), 256'(line_bus.line_resp), 256'(0));
      burst_bus.burst_rdata = rb2[i];
      step();
    end
    check("rd2_line_resp", 256'(line_bus.line_resp), 256'(1));
    check("rd2_line_rdata", line_bus.line_rdata, read_line2);

    // Back-to-back: write presented in the IDLE cycle right after DONE
    line_bus.line_read   = 1'b0;
    burst_bus.burst_resp = 1'b0;
    step();
    check("b2b_idle_resp", 256'(line_bus.line_resp), 256'(0));
    line_bus.line_address = 32'h0000_6078;
    line_bus.line_wdata   = wline;
    line_bus.line_write   = 1'b1;
    step();
    check("b2b_burst_write", 256'(burst_bus.burst_write), 256'(1));
    check("b2b_burst_addr", 256'(burst_bus.burst_address), 256'(32'h0000_6060));
    check("b2b_rdata_kept", line_bus.line_rdata, read_line2);
    burst_bus.burst_resp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_wdata_b%0d", i), 256'(burst_bus.burst_wdata), 256'(wexp[i]));
      step();
    end
    check("b2b_line_resp", 256'(line_bus.line_resp), 256'(1));
    check("b2b_rdata_final", line_bus.line_rdata, read_line2);
    line_bus.line_write  = 1'b0;
    burst_bus.burst_resp = 1'b0;
    step();
    check("b2b_line_resp_after", 256'(line_bus.line_resp), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
